// File: rtl/bip_control.sv
// rtl/bip_control.sv - BIP fetch/decode control: PC, instruction decode, HALT and cycle counter
module bip_control #(
  parameter int NB_BITS   = 16,
  parameter int NB_OPCODE = 5,
  parameter int NB_ADDR   = 11,
  parameter int NB_CYCLES = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_en,
  input  logic [NB_BITS-1:0]   i_instr,
  output logic [NB_ADDR-1:0]   o_pc,
  output logic [NB_ADDR-1:0]   o_operand,
  output logic [1:0]           o_sel_a,
  output logic                 o_sel_b,
  output logic                 o_op_code,
  output logic                 o_wr_acc,
  output logic                 o_wr_ram,
  output logic                 o_rd_ram,
  output logic                 o_halted,
  output logic [NB_CYCLES-1:0] o_cycles
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  localparam logic [NB_OPCODE-1:0] OP_HLT  = NB_OPCODE'(0);
  localparam logic [NB_OPCODE-1:0] OP_STO  = NB_OPCODE'(1);
  localparam logic [NB_OPCODE-1:0] OP_LD   = NB_OPCODE'(2);
  localparam logic [NB_OPCODE-1:0] OP_LDI  = NB_OPCODE'(3);
  localparam logic [NB_OPCODE-1:0] OP_ADD  = NB_OPCODE'(4);
  localparam logic [NB_OPCODE-1:0] OP_ADDI = NB_OPCODE'(5);
  localparam logic [NB_OPCODE-1:0] OP_SUB  = NB_OPCODE'(6);
  localparam logic [NB_OPCODE-1:0] OP_SUBI = NB_OPCODE'(7);

  localparam logic [NB_ADDR-1:0]   PC_ONE  = NB_ADDR'(1);
  localparam logic [NB_CYCLES-1:0] CYC_ONE = NB_CYCLES'(1);
  localparam logic [NB_CYCLES-1:0] CYC_MAX = '1;

  state_t                 r_state;
  logic [NB_ADDR-1:0]     r_pc;
  logic                   r_halted;
  logic [NB_CYCLES-1:0]   r_cycles;

  logic [NB_OPCODE-1:0]   w_opcode;
  logic                   w_run;
  logic                   w_is_hlt;

  assign w_opcode = i_instr[NB_BITS-1 -: NB_OPCODE];
  // An instruction executes only in RUN with the step enable high and no reset pending.
  assign w_run    = (r_state == ST_RUN) && i_en && !i_rst;
  assign w_is_hlt = (w_opcode == OP_HLT);

  // Single-cycle decode: datapath selects and memory strobes follow the fetched opcode.
  always_comb begin
    o_sel_a   = 2'b00;
    o_sel_b   = 1'b0;
    o_op_code = 1'b0;
    o_wr_acc  = 1'b0;
    o_wr_ram  = 1'b0;
    o_rd_ram  = 1'b0;
    if (w_run) begin
      case (w_opcode)
        OP_STO:  o_wr_ram = 1'b1;
        OP_LD: begin
          o_rd_ram = 1'b1;
          o_wr_acc = 1'b1;
        end
        OP_LDI: begin
          o_sel_a  = 2'b01;
          o_wr_acc = 1'b1;
        end
        OP_ADD, OP_SUB: begin
          o_rd_ram  = 1'b1;
          o_sel_a   = 2'b10;
          o_op_code = (w_opcode == OP_ADD);
          o_wr_acc  = 1'b1;
        end
        OP_ADDI, OP_SUBI: begin
          o_sel_a   = 2'b10;
          o_sel_b   = 1'b1;
          o_op_code = (w_opcode == OP_ADDI);
          o_wr_acc  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // RUN/HALT state, PC, halted flag and saturating cycle counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= ST_RUN;
      r_pc     <= '0;
      r_halted <= 1'b0;
      r_cycles <= '0;
    end else if (w_run) begin
      if (r_cycles != CYC_MAX) begin
        r_cycles <= r_cycles + CYC_ONE;
      end
      if (w_is_hlt) begin
        r_state  <= ST_HALT;
        r_halted <= 1'b1;
      end else begin
        r_pc <= r_pc + PC_ONE;
      end
    end
  end

  assign o_pc      = r_pc;
  assign o_operand = i_instr[NB_ADDR-1:0];
  assign o_halted  = r_halted;
  assign o_cycles  = r_cycles;

endmodule

// File: tb/tb_bip_control.sv
// tb/tb_bip_control.sv - directed self-checking bench for bip_control
module tb_bip_control;

  logic        clk;
  logic        rst;
  logic        en;
  logic [15:0] instr;
  logic [15:0] mem [0:2047];

  logic [10:0] pc, operand;
  logic [1:0]  sel_a;
  logic        sel_b, op_code, wr_acc, wr_ram, rd_ram, halted;
  logic [31:0] cycles;

  logic [10:0] s_pc, s_operand;
  logic [1:0]  s_sel_a;
  logic        s_sel_b, s_op_code, s_wr_acc, s_wr_ram, s_rd_ram, s_halted;
  logic [3:0]  s_cycles;

  int total;
  int bad;

  bip_control u_dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_instr(instr),
    .o_pc(pc), .o_operand(operand), .o_sel_a(sel_a), .o_sel_b(sel_b),
    .o_op_code(op_code), .o_wr_acc(wr_acc), .o_wr_ram(wr_ram), .o_rd_ram(rd_ram),
    .o_halted(halted), .o_cycles(cycles)
  );

  bip_control #(.NB_CYCLES(4)) u_small (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_instr(instr),
    .o_pc(s_pc), .o_operand(s_operand), .o_sel_a(s_sel_a), .o_sel_b(s_sel_b),
    .o_op_code(s_op_code), .o_wr_acc(s_wr_acc), .o_wr_ram(s_wr_ram), .o_rd_ram(s_rd_ram),
    .o_halted(s_halted), .o_cycles(s_cycles)
  );

  assign instr = mem[pc];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_nop();
    for (int i = 0; i < 2048; i++) mem[i] = 16'hF800;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    fill_nop();
    mem[0] = 16'h1805;  // LDI 5
    mem[1] = 16'h2803;  // ADDI 3
    mem[2] = 16'h0802;  // STO 2
    mem[3] = 16'h0055;  // HLT (operand 0x55)

    // Reset cycle: enable high but strobes must stay low
    rst = 1'b1;
    en  = 1'b1;
    step();
    step();
    check("rst_pc", {21'd0, pc}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_cycles", cycles, 32'd0);
    check("rst_wr_acc", {31'd0, wr_acc}, 32'd0);

    // Program 1: LDI 5; ADDI 3; STO 2; HLT
    rst = 1'b0;
    #1;
    check("ldi_sel", {28'd0, sel_a, wr_acc, wr_ram}, {28'd0, 2'b01, 1'b1, 1'b0});
    check("ldi_operand", {21'd0, operand}, 32'd5);
    step();
    check("addi_sel", {27'd0, sel_a, sel_b, op_code, wr_acc}, {27'd0, 2'b10, 1'b1, 1'b1, 1'b1});
    check("addi_pc", {21'd0, pc}, 32'd1);
    step();
    check("sto_strobes", {27'd0, wr_ram, wr_acc, rd_ram, sel_a}, {27'd0, 1'b1, 1'b0, 1'b0, 2'b00});
    step();
    check("hlt_strobes", {29'd0, wr_ram, wr_acc, rd_ram}, 32'd0);
    check("hlt_not_yet_halted", {31'd0, halted}, 32'd0);
    step();
    check("halt_pc", {21'd0, pc}, 32'd3);
    check("halt_flag", {31'd0, halted}, 32'd1);
    check("halt_cycles", cycles, 32'd4);
    en = 1'b0;
    step();
    en = 1'b1;
    step();
    step();
    check("halt_frozen", {20'd0, pc, halted}, {20'd0, 11'd3, 1'b1});
    check("halt_cycles_frozen", cycles, 32'd4);
    check("halt_operand", {21'd0, operand}, 32'h55);
    check("halt_no_strobe", {29'd0, wr_ram, wr_acc, rd_ram}, 32'd0);

    // Reset out of HALT, load program 2
    rst = 1'b1;
    mem[0] = 16'h1007;  // LD 7
    mem[1] = 16'h3007;  // SUB 7
    mem[2] = 16'h2001;  // ADD 1
    mem[3] = 16'h0000;  // HLT
    step();
    check("rst_halt_state", {20'd0, pc, halted}, 32'd0);
    check("rst_halt_cycles", cycles, 32'd0);
    rst = 1'b0;
    #1;
    check("ld_strobes", {27'd0, rd_ram, sel_a, wr_acc, wr_ram}, {27'd0, 1'b1, 2'b00, 1'b1, 1'b0});
    check("ld_operand", {21'd0, operand}, 32'd7);
    step();
    check("sub_strobes", {26'd0, rd_ram, sel_a, sel_b, op_code, wr_acc},
          {26'd0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b1});
    check("sub_operand", {21'd0, operand}, 32'd7);
    step();
    check("add_pc", {21'd0, pc}, 32'd2);

    // Enable low for three cycles on ADD
    en = 1'b0;
    #1;
    check("en_low_strobes", {29'd0, wr_ram, wr_acc, rd_ram}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("en_low_pc", {21'd0, pc}, 32'd2);
      check("en_low_cycles", cycles, 32'd2);
    end
    en = 1'b1;
    #1;
    check("add_resume", {27'd0, rd_ram, sel_a, op_code, wr_acc}, {27'd0, 1'b1, 2'b10, 1'b1, 1'b1});
    step();
    check("hlt2_pc", {21'd0, pc}, 32'd3);

    // Reset during the HLT cycle itself
    rst = 1'b1;
    step();
    check("rst_hlt_cycle", {20'd0, pc, halted}, 32'd0);
    check("rst_hlt_cycle_cnt", cycles, 32'd0);

    // NOP stream: saturation of small counter and PC wrap
    fill_nop();
    step();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) step();
    check("sat_small", {28'd0, s_cycles}, 32'd15);
    check("cnt_wide", cycles, 32'd20);
    for (int i = 0; i < 2027; i++) step();
    check("wrap_pre_pc", {21'd0, pc}, 32'h7FF);
    check("wrap_no_strobe", {26'd0, wr_ram, wr_acc, rd_ram, sel_a, sel_b}, 32'd0);
    step();
    check("wrap_pc", {21'd0, pc}, 32'd0);
    check("sat_small_end", {28'd0, s_cycles}, 32'd15);
    check("cnt_wide_end", cycles, 32'd2048);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bip_control.md
# bip_control

Instruction fetch/decode control unit for the BIP accumulator processor. It holds the program counter, reads one 16-bit instruction per cycle from asynchronous-read program memory, and drives the datapath selects (accumulator source, operand mux, ALU op, accumulator write) and the data-memory strobes. It also stops the machine on `HLT` and keeps an executed-cycle counter for the debug unit. It sits between program memory and the datapath/data memory pair.

## Interface
Parameters:
- `NB_BITS`, 16: instruction width.
- `NB_OPCODE`, 5: opcode field width, bits [15:11].
- `NB_ADDR`, 11: operand/address field width, bits [10:0]; also the PC width.
- `NB_CYCLES`, 32: cycle counter width.

Ports:
- `i_clk`, in, 1: single clock; all state updates on the rising edge.
- `i_rst`, in, 1: synchronous, active-high reset.
- `i_en`, in, 1: step enable; when low, the machine freezes and all strobes are 0.
- `i_instr`, in, NB_BITS: instruction at `o_pc`, valid in the same cycle.
- `o_pc`, out, NB_ADDR: program memory address (registered PC).
- `o_operand`, out, NB_ADDR: `i_instr[10:0]`; feeds the datapath immediate and the data memory address.
- `o_sel_a`, out, 2: accumulator source; 00 = memory, 01 = sign-extended immediate, 10 = ALU result.
- `o_sel_b`, out, 1: ALU operand B; 0 = memory, 1 = immediate.
- `o_op_code`, out, 1: ALU op; 1 = add, 0 = subtract.
- `o_wr_acc`, out, 1: accumulator write enable.
- `o_wr_ram`, out, 1: data memory write strobe (stores the accumulator).
- `o_rd_ram`, out, 1: data memory read strobe.
- `o_halted`, out, 1: high in the HALT state.
- `o_cycles`, out, NB_CYCLES: executed-cycle count.

## Operation
- FSM states: RUN and HALT. Reset enters RUN.
- RUN with `i_en`=0: PC, state and counter hold. All strobes (`o_wr_acc`, `o_wr_ram`, `o_rd_ram`) are 0.
- RUN with `i_en`=1: decode `i_instr[15:11]` combinationally and execute:
  - 00000 HLT: no strobes; PC holds; next state HALT.
  - 00001 STO: `o_wr_ram`=1; PC+1.
  - 00010 LD: `o_rd_ram`=1, `o_sel_a`=00, `o_wr_acc`=1; PC+1.
  - 00011 LDI: `o_sel_a`=01, `o_wr_acc`=1; PC+1.
  - 00100 ADD: `o_rd_ram`=1, `o_sel_a`=10, `o_sel_b`=0, `o_op_code`=1, `o_wr_acc`=1; PC+1.
  - 00101 ADDI: `o_sel_a`=10, `o_sel_b`=1, `o_op_code`=1, `o_wr_acc`=1; PC+1.
  - 00110 SUB: as ADD with `o_op_code`=0.
  - 00111 SUBI: as ADDI with `o_op_code`=0.
  - Any other opcode: NOP; no strobes; PC+1.
- Non-strobe outputs (`o_sel_a`, `o_sel_b`, `o_op_code`) are 0 whenever their instruction does not use them.
- HALT: PC, counter and state frozen; all strobes 0; `o_halted`=1. Only `i_rst` leaves HALT. `i_en` is ignored.
- PC increments modulo 2^NB_ADDR: 0x7FF wraps to 0x000.
- Counter: increments once per RUN cycle with `i_en`=1, including the HLT cycle. It saturates at all-ones and never wraps.
- `o_operand` always mirrors `i_instr[10:0]`, including while halted.

## Timing
- Reset values: `o_pc`=0, state RUN, `o_halted`=0, `o_cycles`=0, all strobes 0 during the reset cycle.
- Reset takes priority over everything, including a HLT being decoded and a mid-program reset. The next cycle fetches address 0.
- Single-cycle execution: strobes are combinational from `i_instr` in the fetch cycle. The datapath and memory capture at the same rising edge at which the PC advances.
- `o_pc`, `o_halted` and `o_cycles` are registered and change only on the rising edge.
- Entering HALT: `o_halted` rises on the edge that ends the HLT cycle; `o_pc` stays at the HLT address.
- Deasserting `i_en` mid-program costs no instruction: the same instruction re-executes when `i_en` returns.

## Test plan
- Reset then program `LDI 5; ADDI 3; STO 2; HLT` at addresses 0-3, `i_en`=1 -> per cycle, `o_sel_a`/`o_wr_acc` = 01/1, then 10/1 with `o_sel_b`=1 and `o_op_code`=1, then `o_wr_ram`=1, then HALT. Final state: `o_pc`=3, `o_halted`=1, `o_cycles`=4.
- `LD 7; SUB 7` -> `o_rd_ram`=1 on both; `o_sel_b`=0 on SUB; `o_op_code`=0 on SUB; `o_operand`=7.
- Toggle `i_en` low for 3 cycles mid-program -> `o_pc` and `o_cycles` unchanged; strobes 0; execution resumes at the same instruction.
- Opcode 11111 at PC=0x7FF -> no strobes; `o_pc` wraps to 0x000.
- Assert `i_rst` during HALT and also during the HLT cycle -> `o_pc`=0, `o_halted`=0, `o_cycles`=0 on the next cycle.
- Counter with `NB_CYCLES`=4 over 20 running cycles -> `o_cycles` holds at 15.
